// File: rtl/main_memory_refill.sv
// Main-memory backing store: fixed-latency 4-word block refills and single-word write-throughs.
// Define MEM_STATS_EN to enable the saturating read/write statistics counters.
`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module main_memory_refill #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int MEM_DEPTH       = 16384,
  parameter int LATENCY         = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_write,
  input  logic [`ADDRESS_LEN-1:0]              req_addr,
  input  logic [`WORD_LEN-1:0]                 req_wdata,
  output logic                                 resp_valid,
  output logic [`WORD_LEN*WORDS_PER_BLOCK-1:0] resp_block,
  output logic                                 wr_done,
  output logic [`ADDRESS_LEN-1:0]              read_count,
  output logic [`ADDRESS_LEN-1:0]              write_count
);

  localparam int AW     = `ADDRESS_LEN;
  localparam int WW     = `WORD_LEN;
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int BEAT_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam int WAIT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, RESP} state_t;

  state_t                      state_q, state_d;
  logic [WAIT_W-1:0]           wait_q, wait_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic                        write_q;
  logic [IDX_W-1:0]            idx_q;
  logic [WW-1:0]               wdata_q;
  logic [WW*WORDS_PER_BLOCK-1:0] block_q;

  logic [WW-1:0]               mem [MEM_DEPTH];
  logic [IDX_W-1:0]            rdIdx;
  logic [WW-1:0]               rdWord;
  logic                        accept, waitDone, burstDone, commit;
  logic                        unusedAddrBits;

  assign unusedAddrBits = ^req_addr[AW-1:IDX_W];

  // Words are stored XORed with their own index, so a zero-initialised array reads back mem[i] = i.
  assign rdIdx  = {idx_q[IDX_W-1:BEAT_W], beat_q};
  assign rdWord = mem[rdIdx] ^ WW'(rdIdx);

  assign accept    = (state_q == IDLE) && req_valid;
  assign waitDone  = (state_q == WAIT) && (wait_q == WAIT_W'(LATENCY - 1));
  assign burstDone = (state_q == BURST) && (beat_q == BEAT_W'(WORDS_PER_BLOCK - 1));
  assign commit    = waitDone && write_q;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP) && !write_q;
  assign wr_done    = (state_q == RESP) && write_q;
  assign resp_block = block_q;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          wait_d  = '0;
        end
      end
      WAIT: begin
        wait_d = wait_q + 1'b1;
        if (waitDone) begin
          state_d = write_q ? RESP : BURST;
          wait_d  = '0;
          beat_d  = '0;
        end
      end
      BURST: begin
        beat_d = beat_q + 1'b1;
        if (burstDone) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      beat_q  <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      if (state_q == BURST) block_q[int'(beat_q)*WW +: WW] <= rdWord;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      write_q <= req_write;
      idx_q   <= req_addr[IDX_W-1:0];
      wdata_q <= req_wdata;
    end
  end

  // Storage is deliberately outside reset; a reset during WAIT simply suppresses the commit.
  always_ff @(posedge clk) begin
    if (!rst && commit) mem[idx_q] <= wdata_q ^ WW'(idx_q);
  end

`ifdef MEM_STATS_EN
  logic [AW-1:0] readCnt_q, writeCnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      readCnt_q  <= '0;
      writeCnt_q <= '0;
    end else begin
      if (resp_valid && !(&readCnt_q)) readCnt_q <= readCnt_q + 1'b1;
      if (wr_done && !(&writeCnt_q)) writeCnt_q <= writeCnt_q + 1'b1;
    end
  end

  assign read_count  = readCnt_q;
  assign write_count = writeCnt_q;
`else
  assign read_count  = '0;
  assign write_count = '0;
`endif

endmodule

// File: tb/tb_main_memory_refill.sv
// Scoreboard bench for main_memory_refill: stimulus pushes expected responses, a negedge monitor pops and compares.
// Counter expectations follow MEM_STATS_EN the same way as the design.
module tb_main_memory_refill;

  localparam int W     = 4;
  localparam int DEPTH = 16384;
  localparam int LAT   = 4;
  localparam int AW    = 32;
  localparam int WW    = 32;
  localparam int BW    = WW * W;

  typedef struct {
    bit             isWrite;
    logic [BW-1:0]  block;
    int             acceptCyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [WW-1:0] req_wdata;
  logic          resp_valid, wr_done;
  logic [BW-1:0] resp_block;
  logic [AW-1:0] read_count, write_count;

  main_memory_refill #(.WORDS_PER_BLOCK(W), .MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_block(resp_block), .wr_done(wr_done),
    .read_count(read_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            nReads = 0;
  int            nWrites = 0;
  bit            ignoreMon = 1'b1;
  logic [BW-1:0] lastBlock = '0;
  logic [WW-1:0] refMem [DEPTH];
  exp_t          sb[$];
  exp_t          monE;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare one observed value with its required value and log a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference block: aligned base after index truncation, word 0 in the LSBs.
  task automatic expBlock(input int unsigned addr, output logic [BW-1:0] b);
    int unsigned base;
    base = (addr % DEPTH) & ~(W - 1);
    for (int k = 0; k < W; k++) b[k*WW +: WW] = refMem[base + k];
  endtask

  // Present a request, hold it until the DUT accepts, then queue the expected response.
  task automatic applyStimulus(input bit wr, input int unsigned addr, input logic [WW-1:0] data,
                               output int acc);
    exp_t e;
    int   budget;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = data;
    budget = 0;
    while (!req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout actual=busy required=ready (addr %0d)", addr);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc         = cyc;
    e.isWrite   = wr;
    e.acceptCyc = cyc;
    e.block     = '0;
    if (wr) refMem[addr % DEPTH] = data;
    else expBlock(addr, e.block);
    sb.push_back(e);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() != 0 && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: every response pulse pops the oldest expectation; ready must track the outstanding request.
  always @(negedge clk) begin
    if (!rst && !ignoreMon) begin
      checkOutput("req_ready", BW'(req_ready), BW'(sb.size() == 0));
      if (resp_valid || wr_done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL spurious_pulse actual=%b%b required=00", resp_valid, wr_done);
        end else begin
          monE = sb.pop_front();
          checkOutput("resp_kind", BW'({resp_valid, wr_done}), monE.isWrite ? BW'(2'b01) : BW'(2'b10));
          checkOutput("latency", BW'(cyc), BW'(monE.acceptCyc + (monE.isWrite ? LAT : LAT + W)));
          if (!monE.isWrite) begin
            checkOutput("resp_block", resp_block, monE.block);
            lastBlock = monE.block;
            nReads++;
          end else begin
            checkOutput("block_hold", resp_block, lastBlock);
            nWrites++;
          end
        end
      end
    end
  end

  initial begin
    int a1, a2;
    bit wr;
    int unsigned addr;
    for (int i = 0; i < DEPTH; i++) refMem[i] = WW'(i);
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_ready", BW'(req_ready), BW'(1));
    checkOutput("reset_resp_valid", BW'(resp_valid), BW'(0));
    checkOutput("reset_wr_done", BW'(wr_done), BW'(0));
    checkOutput("reset_block", resp_block, '0);
    checkOutput("reset_read_count", BW'(read_count), BW'(0));
    checkOutput("reset_write_count", BW'(write_count), BW'(0));
    ignoreMon = 1'b0;

    applyStimulus(1'b0, 1026, '0, a1);
    drain();
    checkOutput("read_1026", resp_block, {32'd1027, 32'd1026, 32'd1025, 32'd1024});

    applyStimulus(1'b1, 1025, 32'hDEAD, a1);
    applyStimulus(1'b0, 1024, '0, a1);
    drain();
    checkOutput("write_through_word1", BW'(resp_block[WW +: WW]), BW'(32'hDEAD));

    applyStimulus(1'b0, 16383, '0, a1);
    drain();
    checkOutput("read_top", resp_block, {32'd16383, 32'd16382, 32'd16381, 32'd16380});
    applyStimulus(1'b0, 16384 + 5, '0, a1);
    drain();
    checkOutput("read_alias", resp_block, {32'd7, 32'd6, 32'd5, 32'd4});

    // Second request is held while the first burst is in flight.
    applyStimulus(1'b0, 100, '0, a1);
    applyStimulus(1'b0, 200, '0, a2);
    checkOutput("b2b_accept_edge", BW'(a2), BW'(a1 + LAT + W + 2));
    drain();

    // Reset two cycles into the WAIT of a write must drop it silently.
    ignoreMon = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 2000;
    req_wdata = 32'h1234;
    checkOutput("rst_test_ready", BW'(req_ready), BW'(1));
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    lastBlock = '0;
    nReads    = 0;
    nWrites   = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      checkOutput("rst_no_wr_done", BW'(wr_done), BW'(0));
      checkOutput("rst_ready", BW'(req_ready), BW'(1));
    end
    checkOutput("rst_block_cleared", resp_block, '0);
    checkOutput("rst_read_count", BW'(read_count), BW'(0));
    ignoreMon = 1'b0;
    applyStimulus(1'b0, 2000, '0, a1);
    drain();
    checkOutput("rst_mem_kept", BW'(resp_block[0 +: WW]), BW'(32'd2000));

    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 255);
      applyStimulus(wr, addr, $urandom, a1);
    end
    drain();
    repeat (2) @(negedge clk);

`ifdef MEM_STATS_EN
    checkOutput("read_count", BW'(read_count), BW'(nReads));
    checkOutput("write_count", BW'(write_count), BW'(nWrites));
`else
    checkOutput("read_count", BW'(read_count), BW'(0));
    checkOutput("write_count", BW'(write_count), BW'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
